multiply_accumulate_unit: RTL
=============================

Name: multiply_accumulate_unit

Overview:
Parametrised, pipelined multiply/multiply-accumulate unit for the processor's execute stage. It replaces single-cycle multiplication with a STAGES-deep pipeline that uses a valid/ready handshake. Writeback tags travel with each operation, and the unit exposes a hazard query so decode can stall on in-flight destinations. Supports mul, mla, umull, umlal, smull and smlal at WIDTH bits.

Parameters:
WIDTH, 32, operand width; results are 2*WIDTH.
STAGES, 3, pipeline depth (1..8); latency from accept to out_valid.
TAG_W, 4, register-tag width.

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operation offered
in_ready  output  1  unit accepts this cycle
in_opcode  input  4  0000 mul, 0001 mla, 0100 umull, 0101 umlal, 0110 smull, 0111 smlal
in_a, in_b  input  WIDTH  multiplicands
in_c  input  WIDTH  addend (mla) / accumulator high word (umlal, smlal)
in_d  input  WIDTH  accumulator low word (umlal, smlal)
in_dest_lo, in_dest_hi  input  TAG_W  destination tags (low word, high word)
in_set_flags  input  1  operation updates N/Z
flush  input  1  synchronous pipeline kill
out_valid  output  1  result available
out_ready  input  1  consumer accepts
out_result  output  2*WIDTH  result
out_writeback  output  2  0 none, 1 low word to dest_lo, 3 high to dest_hi and low to dest_lo
out_dest_lo, out_dest_hi  output  TAG_W  carried tags
out_flags  output  2  {N,Z}
out_flags_valid  output  1  carried in_set_flags
hazard_tag  input  TAG_W  register queried by decode
hazard  output  1  hazard_tag is a pending destination

Behaviour:
- Reset (async, rst_n=0): all stage valid bits 0, out_valid=0, out_result=0, out_writeback=0, out_flags=0, out_flags_valid=0, out tags 0. Reset mid-operation discards all in-flight operations. Operation resumes on the first edge after rst_n rises.
- Pipeline moves as one unit: in_ready = !flush && (!out_valid || out_ready). When in_ready=1, every stage shifts forward one position on the edge. Stage 0 loads in_valid and the operands; empty slots (bubbles) propagate and are not collapsed.
- Accept occurs when in_valid && in_ready. Output handshake completes when out_valid && out_ready. With out_ready held at 1, a result accepted at edge k appears with out_valid=1 after edge k+STAGES-1 and before edge k+STAGES (STAGES=1: registered, visible the cycle after accept). Throughput is one operation per cycle.
- Under backpressure (out_valid=1, out_ready=0), all stages hold and the out_* signals remain stable.
- Arithmetic, with P = in_a*in_b:
  - mul: low WIDTH of P; upper half zero; writeback 1.
  - mla: low WIDTH of P+in_c; upper half zero; writeback 1.
  - umull: unsigned 2W product; writeback 3.
  - umlal: unsigned P + {in_c,in_d} mod 2^(2W); writeback 3.
  - smull: signed product; writeback 3.
  - smlal: signed P + {in_c,in_d} mod 2^(2W); writeback 3.
  - Any other opcode: accepted and passed through, result 0, writeback 0, flags_valid 0.
- Flags: N = bit WIDTH-1 for writeback-1 ops and bit 2W-1 for long ops. Z = 1 when the relevant width is all zero. out_flags_valid = in_set_flags for defined ops.
- flush=1: every valid bit clears on the edge, and the input is not accepted that cycle. out_valid=0 on the next cycle. Flush overrides backpressure. Flush together with rst_n=0: reset wins.
- hazard is combinational from registered state. It is 1 if any valid stage, including the output stage, has writeback!=0 and dest_lo==hazard_tag, or writeback==3 and dest_hi==hazard_tag. The operation being presented at the input is not included.
- When dest_hi==dest_lo on a long op, both tags are carried unchanged; resolving the conflict is the consumer's responsibility.

Test Plan:
- STAGES=3, mul a=7,b=6, out_ready=1 -> out_valid 3 cycles after accept, result 0x..0000002A, writeback 1, N=0, Z=0.
- smull a=0xFFFFFFFE(-2), b=3 -> result 0xFFFFFFFF_FFFFFFFA, writeback 3, N=1; umlal a=b=0xFFFFFFFF, c=0, d=1 -> 0xFFFFFFFE_00000002.
- Back-to-back 5 ops, out_ready low for 4 cycles mid-stream -> in_ready=0 while stalled, outputs held stable, all 5 results emerge in order with none lost or duplicated.
- Two ops in flight (dest_lo=3; dest_lo=5, dest_hi=6, umull) -> hazard=1 for tags 3/5/6, 0 for 4; after drain hazard=0 for all.
- flush asserted with 3 ops in flight and in_valid=1 -> in_ready=0 that cycle, out_valid=0 for the following STAGES cycles, hazard=0.
- rst_n pulsed low asynchronously between edges while pipe full -> out_valid and hazard drop immediately; first op after release has normal latency; STAGES=1 build passes the same stream.

Source files
------------

// File: rtl/multiply_accumulate_unit.sv
// Pipelined multiply / multiply-accumulate unit with valid/ready handshake,
// carried writeback tags, N/Z flags and a destination hazard query.
// Arithmetic is resolved ahead of stage 0; later stages carry the result.
module multiply_accumulate_unit #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned STAGES = 3,
    parameter int unsigned TAG_W  = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [3:0]           in_opcode,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    input  logic [WIDTH-1:0]     in_c,
    input  logic [WIDTH-1:0]     in_d,
    input  logic [TAG_W-1:0]     in_dest_lo,
    input  logic [TAG_W-1:0]     in_dest_hi,
    input  logic                 in_set_flags,
    input  logic                 flush,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   out_result,
    output logic [1:0]           out_writeback,
    output logic [TAG_W-1:0]     out_dest_lo,
    output logic [TAG_W-1:0]     out_dest_hi,
    output logic [1:0]           out_flags,
    output logic                 out_flags_valid,
    input  logic [TAG_W-1:0]     hazard_tag,
    output logic                 hazard
);

    localparam int unsigned RW   = 2 * WIDTH;
    localparam int unsigned LAST = STAGES - 1;

    localparam logic [3:0] OP_MUL   = 4'b0000;
    localparam logic [3:0] OP_MLA   = 4'b0001;
    localparam logic [3:0] OP_UMULL = 4'b0100;
    localparam logic [3:0] OP_UMLAL = 4'b0101;
    localparam logic [3:0] OP_SMULL = 4'b0110;
    localparam logic [3:0] OP_SMLAL = 4'b0111;

    localparam logic [1:0] WB_NONE = 2'd0;
    localparam logic [1:0] WB_LO   = 2'd1;
    localparam logic [1:0] WB_BOTH = 2'd3;

    logic [RW-1:0]    a_u, b_u, a_s, b_s;
    logic [RW-1:0]    prod_u, prod_s, acc;
    logic [WIDTH-1:0] short_mla;
    logic [RW-1:0]    calc_res;
    logic [1:0]       calc_wb;
    logic [1:0]       calc_flags;
    logic             calc_fv;

    logic [STAGES-1:0] vld_q;
    logic [STAGES-1:0] fv_q;
    logic [RW-1:0]     res_q [STAGES];
    logic [1:0]        wb_q  [STAGES];
    logic [1:0]        fl_q  [STAGES];
    logic [TAG_W-1:0]  dlo_q [STAGES];
    logic [TAG_W-1:0]  dhi_q [STAGES];

    // Whole pipe advances together; a flush blocks the input for the cycle
    assign in_ready = !flush && (!vld_q[LAST] || out_ready);

    // Decode the incoming operation and compute its result and flags
    always_comb begin
        a_u        = {{WIDTH{1'b0}}, in_a};
        b_u        = {{WIDTH{1'b0}}, in_b};
        a_s        = {{WIDTH{in_a[WIDTH-1]}}, in_a};
        b_s        = {{WIDTH{in_b[WIDTH-1]}}, in_b};
        prod_u     = a_u * b_u;
        prod_s     = a_s * b_s;
        acc        = {in_c, in_d};
        short_mla  = prod_u[WIDTH-1:0] + in_c;
        calc_res   = '0;
        calc_wb    = WB_NONE;
        calc_flags = 2'b00;
        calc_fv    = 1'b0;
        case (in_opcode)
            OP_MUL: begin
                calc_res = {{WIDTH{1'b0}}, prod_u[WIDTH-1:0]};
                calc_wb  = WB_LO;
            end
            OP_MLA: begin
                calc_res = {{WIDTH{1'b0}}, short_mla};
                calc_wb  = WB_LO;
            end
            OP_UMULL: begin
                calc_res = prod_u;
                calc_wb  = WB_BOTH;
            end
            OP_UMLAL: begin
                calc_res = prod_u + acc;
                calc_wb  = WB_BOTH;
            end
            OP_SMULL: begin
                calc_res = prod_s;
                calc_wb  = WB_BOTH;
            end
            OP_SMLAL: begin
                calc_res = prod_s + acc;
                calc_wb  = WB_BOTH;
            end
            default: begin
                calc_res = '0;
                calc_wb  = WB_NONE;
            end
        endcase
        if (calc_wb == WB_LO) begin
            calc_flags = {calc_res[WIDTH-1], (calc_res[WIDTH-1:0] == '0)};
        end else if (calc_wb == WB_BOTH) begin
            calc_flags = {calc_res[RW-1], (calc_res == '0)};
        end
        calc_fv = (calc_wb != WB_NONE) && in_set_flags;
    end

    // Pipeline registers: stage 0 loads the input, later stages shift forward
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            fv_q  <= '0;
            for (int i = 0; i < int'(STAGES); i++) begin
                res_q[i] <= '0;
                wb_q[i]  <= WB_NONE;
                fl_q[i]  <= 2'b00;
                dlo_q[i] <= '0;
                dhi_q[i] <= '0;
            end
        end else if (flush) begin
            vld_q <= '0;
        end else if (in_ready) begin
            vld_q[0] <= in_valid;
            fv_q[0]  <= calc_fv;
            res_q[0] <= calc_res;
            wb_q[0]  <= calc_wb;
            fl_q[0]  <= calc_flags;
            dlo_q[0] <= in_dest_lo;
            dhi_q[0] <= in_dest_hi;
            for (int i = 1; i < int'(STAGES); i++) begin
                vld_q[i] <= vld_q[i-1];
                fv_q[i]  <= fv_q[i-1];
                res_q[i] <= res_q[i-1];
                wb_q[i]  <= wb_q[i-1];
                fl_q[i]  <= fl_q[i-1];
                dlo_q[i] <= dlo_q[i-1];
                dhi_q[i] <= dhi_q[i-1];
            end
        end
    end

    assign out_valid       = vld_q[LAST];
    assign out_result      = res_q[LAST];
    assign out_writeback   = wb_q[LAST];
    assign out_dest_lo     = dlo_q[LAST];
    assign out_dest_hi     = dhi_q[LAST];
    assign out_flags       = fl_q[LAST];
    assign out_flags_valid = fv_q[LAST];

    // Hazard: any valid in-flight op that will write the queried register
    always_comb begin
        hazard = 1'b0;
        for (int i = 0; i < int'(STAGES); i++) begin
            if (vld_q[i]) begin
                if ((wb_q[i] != WB_NONE) && (dlo_q[i] == hazard_tag)) begin
                    hazard = 1'b1;
                end
                if ((wb_q[i] == WB_BOTH) && (dhi_q[i] == hazard_tag)) begin
                    hazard = 1'b1;
                end
            end
        end
    end

endmodule
